image_stream_loader: RTL

Byte-stream frame loader that fills the pixel BRAM consumed by `image_processor_bram`, then kicks off processing. It accepts an 8-bit R,G,B byte stream over a valid/ready handshake and packs each three-byte group into a 24-bit pixel word `{R,G,B}`. It writes the words sequentially to the BRAM write port. After the last pixel of a frame is written, it pulses `start` and holds off new input until the processor reports `done`. This block replaces hierarchical BRAM preloading as the system's write-side path into the processor.

---
 rtl/image_stream_loader.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/image_stream_loader.sv
// Packs an R,G,B byte stream into 24-bit pixel words and writes them to the processor's BRAM,
// then pulses proc_start and waits for proc_done before accepting the next frame.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for load_en; no bytes accepted
// S_LOAD      | accepting bytes; one BRAM write per completed pixel
// S_LAST_WR   | final pixel write on the bus; input held off
// S_START     | proc_start pulse cycle
// S_WAIT_DONE | waiting for the processor's done; input held off
module image_stream_loader #(
  parameter int IMAGE_WIDTH  = 4,
  parameter int IMAGE_HEIGHT = 4,
  parameter int ADDR_WIDTH   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load_en,
  input  logic                  i_abort,
  input  logic [7:0]            i_byte_in,
  input  logic                  i_byte_valid,
  output logic                  o_byte_ready,
  output logic                  o_bram_we,
  output logic [ADDR_WIDTH-1:0] o_bram_addr,
  output logic [23:0]           o_bram_wdata,
  output logic                  o_proc_start,
  input  logic                  i_proc_done,
  output logic                  o_busy,
  output logic [7:0]            o_frame_count
);

  localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(IMAGE_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LAST_WR,
    S_START,
    S_WAIT_DONE
  } state_t;

  state_t                r_state;
  logic [1:0]            r_phase;
  logic [ADDR_WIDTH-1:0] r_pix_cnt;
  logic [15:0]           r_shift;
  logic                  w_accept;

  // abort wins over a byte offered in the same cycle; that byte is dropped
  assign w_accept = i_byte_valid && o_byte_ready && !i_abort;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_phase       <= 2'd0;
      r_pix_cnt     <= '0;
      r_shift       <= '0;
      o_byte_ready  <= 1'b0;
      o_bram_we     <= 1'b0;
      o_bram_addr   <= '0;
      o_bram_wdata  <= '0;
      o_proc_start  <= 1'b0;
      o_busy        <= 1'b0;
      o_frame_count <= '0;
    end else begin
      o_bram_we    <= 1'b0;
      o_proc_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_load_en) begin
            r_pix_cnt    <= '0;
            r_phase      <= 2'd0;
            r_state      <= S_LOAD;
            o_byte_ready <= 1'b1;
            o_busy       <= 1'b1;
          end
        end
        S_LOAD: begin
          if (i_abort) begin
            r_state      <= S_IDLE;
            o_byte_ready <= 1'b0;
            o_busy       <= 1'b0;
          end else if (w_accept) begin
            case (r_phase)
              2'd0: begin
                r_shift[15:8] <= i_byte_in;
                r_phase       <= 2'd1;
              end
              2'd1: begin
                r_shift[7:0] <= i_byte_in;
                r_phase      <= 2'd2;
              end
              default: begin
                r_phase      <= 2'd0;
                o_bram_we    <= 1'b1;
                o_bram_addr  <= r_pix_cnt;
                o_bram_wdata <= {r_shift, i_byte_in};
                if (r_pix_cnt == LAST_PIX) begin
                  r_state      <= S_LAST_WR;
                  o_byte_ready <= 1'b0;
                end else begin
                  r_pix_cnt <= r_pix_cnt + 1'b1;
                end
              end
            endcase
          end
        end
        S_LAST_WR: begin
          if (i_abort) begin
            r_state <= S_IDLE;
            o_busy  <= 1'b0;
          end else begin
            r_state      <= S_START;
            o_proc_start <= 1'b1;
          end
        end
        S_START: begin
          r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (i_proc_done) begin
            o_frame_count <= o_frame_count + 8'd1;
            if (i_load_en) begin
              r_pix_cnt    <= '0;
              r_phase      <= 2'd0;
              r_state      <= S_LOAD;
              o_byte_ready <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              o_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state      <= S_IDLE;
          o_byte_ready <= 1'b0;
          o_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
